// File: rtl/vga_scan_timer.sv
// Raster timing generator: pixel-clock divider plus horizontal/vertical scan counters
// with registered, mutually aligned blank/sync/start decodes for the renderers and VGA port.
module vga_scan_timer #(
    parameter int CLK_DIV  = 2,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_ACT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_tick,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        blank,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]   V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0]   H_VIS_C  = 11'(H_VIS);
    localparam logic [10:0]   V_VIS_C  = 11'(V_VIS);
    localparam logic [10:0]   HS_BEG   = 11'(H_VIS + H_FP);
    localparam logic [10:0]   HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0]   VS_BEG   = 11'(V_VIS + V_FP);
    localparam logic [10:0]   VS_END   = 11'(V_VIS + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick_q, tick_d;
    logic [10:0]   x_q, x_d, y_q, y_d;
    logic          blank_q, blank_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          line_q, line_d, frame_q, frame_d;

    // Decodes are taken from the next-state coordinates so they land on the same edge as x/y.
    always_comb begin
        tick_d    = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick_d ? '0 : div_cnt_q + DW'(1);
        x_d       = x_q;
        y_d       = y_q;
        if (tick_d) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
        end
        blank_d = !((x_d < H_VIS_C) && (y_d < V_VIS_C));
        hsync_d = ((x_d >= HS_BEG) && (x_d < HS_END)) ? SYNC_ACT : !SYNC_ACT;
        vsync_d = ((y_d >= VS_BEG) && (y_d < VS_END)) ? SYNC_ACT : !SYNC_ACT;
        line_d  = tick_d && (x_d == '0);
        frame_d = line_d && (y_d == '0);
    end

    // Reset parks the scan on the last pixel so the first tick lands cleanly on (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            x_q       <= H_LAST;
            y_q       <= V_LAST;
            blank_q   <= 1'b1;
            hsync_q   <= !SYNC_ACT;
            vsync_q   <= !SYNC_ACT;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            x_q       <= x_d;
            y_q       <= y_d;
            blank_q   <= blank_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            line_q    <= line_d;
            frame_q   <= frame_d;
        end
    end

    assign pix_tick    = tick_q;
    assign x           = x_q;
    assign y           = y_q;
    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: two instances (full-width lines with short frames, and a tiny
// CLK_DIV=1 raster) checked every clk against a tick-count model, plus literal spot checks.
module tb_vga_scan_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit tick;
        int x;
        int y;
        bit blank;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
    } exp_t;

    // k = number of clk edges seen with reset released. Tick n happens on edge n*cdiv and puts
    // the beam at raster position n-1 in row-major order.
    function automatic exp_t model(input int k, input int cdiv,
                                   input int hv, input int hfp, input int hsw, input int hbp,
                                   input int vv, input int vfp, input int vsw, input int vbp,
                                   input bit act);
        exp_t e;
        int   ht, vt, n, p;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        n  = k / cdiv;
        e.tick = (k > 0) && (k % cdiv == 0);
        if (n == 0) begin
            e.x = ht - 1; e.y = vt - 1; e.blank = 1'b1;
            e.hs = !act; e.vs = !act; e.ls = 1'b0; e.fs = 1'b0;
        end else begin
            p = (n - 1) % (ht * vt);
            e.x = p % ht;
            e.y = p / ht;
            e.blank = !(e.x < hv && e.y < vv);
            e.hs = (e.x >= hv + hfp && e.x < hv + hfp + hsw) ? act : !act;
            e.vs = (e.y >= vv + vfp && e.y < vv + vfp + vsw) ? act : !act;
            e.ls = e.tick && (e.x == 0);
            e.fs = e.ls && (e.y == 0);
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Instance A: standard 800-pixel lines, short 13-line frames, CLK_DIV=2.
    logic        rst_a = 1'b0;
    logic        tick_a, blank_a, hs_a, vs_a, ls_a, fs_a;
    logic [10:0] x_a, y_a;

    vga_scan_timer #(
        .CLK_DIV(2), .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACT(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst_a), .pix_tick(tick_a), .x(x_a), .y(y_a), .blank(blank_a),
        .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
    );

    // Instance B: tiny raster, one pixel per clk, active-high syncs.
    logic        rst_b = 1'b0;
    logic        tick_b, blank_b, hs_b, vs_b, ls_b, fs_b;
    logic [10:0] x_b, y_b;

    vga_scan_timer #(
        .CLK_DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_VIS(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACT(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_tick(tick_b), .x(x_b), .y(y_b), .blank(blank_b),
        .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
    );

    int k_a = 0;
    int k_b = 0;

    always @(posedge clk) begin
        exp_t e;
        if (rst_a) k_a++; else k_a = 0;
        #1;
        e = model(k_a, 2, 640, 16, 96, 48, 6, 2, 2, 3, 1'b0);
        cmp("a_tick", tick_a, e.tick);
        cmp("a_x", x_a, e.x);
        cmp("a_y", y_a, e.y);
        cmp("a_blank", blank_a, e.blank);
        cmp("a_hsync", hs_a, e.hs);
        cmp("a_vsync", vs_a, e.vs);
        cmp("a_line_start", ls_a, e.ls);
        cmp("a_frame_start", fs_a, e.fs);
    end

    always @(posedge clk) begin
        exp_t e;
        if (rst_b) k_b++; else k_b = 0;
        #1;
        e = model(k_b, 1, 4, 1, 1, 1, 2, 1, 1, 1, 1'b1);
        cmp("b_tick", tick_b, e.tick);
        cmp("b_x", x_b, e.x);
        cmp("b_y", y_b, e.y);
        cmp("b_blank", blank_b, e.blank);
        cmp("b_hsync", hs_b, e.hs);
        cmp("b_vsync", vs_b, e.vs);
        cmp("b_line_start", ls_b, e.ls);
        cmp("b_frame_start", fs_b, e.fs);
    end

    task automatic wait_a(input int tx, input int ty, input int budget);
        int left;
        left = budget;
        do begin
            @(posedge clk); #2;
            left--;
        end while (!(tick_a && x_a == tx && y_a == ty) && left > 0);
        if (!(tick_a && x_a == tx && y_a == ty)) cmp("a_wait_timeout", 0, 1);
    endtask

    // Counts edges from reset release to the first pix_tick and checks the (0,0) start.
    task automatic first_tick_a();
        int e;
        e = 0;
        do begin
            @(posedge clk); #2;
            e++;
        end while (!tick_a && e < 10);
        cmp("a_first_tick_clk", e, 2);
        cmp("a_first_x", x_a, 0);
        cmp("a_first_y", y_a, 0);
        cmp("a_first_blank", blank_a, 0);
        cmp("a_first_fs", fs_a, 1);
        cmp("a_first_ls", ls_a, 1);
    endtask

    task automatic seq_a();
        int clks, hs_lo, hs_first, hs_last, vs_lo, vis, hs_tot, tx, ty, hold;
        repeat (3) @(negedge clk);
        #1;
        cmp("a_rst_x", x_a, 799);
        cmp("a_rst_hsync", hs_a, 1);
        @(negedge clk); rst_a = 1'b1;
        first_tick_a();
        do begin @(posedge clk); #2; end while (!tick_a);
        cmp("a_second_x", x_a, 1);
        cmp("a_second_fs", fs_a, 0);
        cmp("a_second_ls", ls_a, 0);

        wait_a(639, 0, 2000);
        cmp("a_x639_blank", blank_a, 0);
        do begin @(posedge clk); #2; end while (!tick_a);
        cmp("a_x640_x", x_a, 640);
        cmp("a_x640_blank", blank_a, 1);

        wait_a(0, 1, 2000);
        cmp("a_wrap_ls", ls_a, 1);
        hs_lo = 0; hs_first = -1; hs_last = -1; clks = 0;
        do begin
            if (tick_a && !hs_a) begin
                hs_lo++;
                if (hs_first < 0) hs_first = x_a;
                hs_last = x_a;
            end
            @(posedge clk); #2;
            clks++;
        end while (!ls_a && clks < 3000);
        cmp("a_hsync_ticks", hs_lo, 96);
        cmp("a_hsync_first_x", hs_first, 656);
        cmp("a_hsync_last_x", hs_last, 751);
        cmp("a_line_clks", clks, 1600);

        clks = 0;
        while (!fs_a && clks < 25000) begin @(posedge clk); #2; clks++; end
        vs_lo = 0; vis = 0; hs_tot = 0; clks = 0;
        do begin
            if (tick_a && !vs_a) vs_lo++;
            if (tick_a && !blank_a) vis++;
            if (tick_a && !hs_a) hs_tot++;
            @(posedge clk); #2;
            clks++;
        end while (!fs_a && clks < 25000);
        cmp("a_frame_clks", clks, 20800);
        cmp("a_vsync_ticks", vs_lo, 1600);
        cmp("a_visible_ticks", vis, 3840);
        cmp("a_hsync_frame_ticks", hs_tot, 1248);

        // Mid-frame reset while inside hsync; must be seen before any clk edge.
        tx = $urandom_range(751, 656);
        ty = $urandom_range(5, 0);
        wait_a(tx, ty, 25000);
        #1 rst_a = 1'b0;
        #1;
        cmp("a_async_x", x_a, 799);
        cmp("a_async_y", y_a, 12);
        cmp("a_async_blank", blank_a, 1);
        cmp("a_async_hsync", hs_a, 1);
        cmp("a_async_vsync", vs_a, 1);
        cmp("a_async_tick", tick_a, 0);
        hold = $urandom_range(5, 1);
        repeat (hold) @(negedge clk);
        rst_a = 1'b1;
        first_tick_a();
    endtask

    task automatic seq_b();
        int clks, hs_hi, vs_hi, gap, hold;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        clks = 0;
        while (!fs_b && clks < 10) begin @(posedge clk); #2; clks++; end
        cmp("b_first_fs_clk", clks, 1);
        hs_hi = 0; vs_hi = 0; clks = 0;
        do begin
            if (hs_b) begin
                hs_hi++;
                cmp("b_hsync_x", x_b, 5);
            end
            if (vs_b) begin
                vs_hi++;
                cmp("b_vsync_y", y_b, 3);
            end
            @(posedge clk); #2;
            clks++;
        end while (!fs_b && clks < 100);
        cmp("b_frame_clks", clks, 35);
        cmp("b_hsync_ticks", hs_hi, 5);
        cmp("b_vsync_ticks", vs_hi, 7);
        for (int r = 0; r < 4; r++) begin
            gap = $urandom_range(60, 1);
            repeat (gap) @(posedge clk);
            #($urandom_range(8, 3));
            rst_b = 1'b0;
            #1;
            cmp("b_async_x", x_b, 6);
            cmp("b_async_y", y_b, 4);
            cmp("b_async_hsync", hs_b, 0);
            cmp("b_async_vsync", vs_b, 0);
            cmp("b_async_tick", tick_b, 0);
            hold = $urandom_range(4, 1);
            repeat (hold) @(negedge clk);
            rst_b = 1'b1;
        end
        repeat (80) @(posedge clk);
    endtask

    initial begin
        fork
            seq_a();
            seq_b();
        join
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
